// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART receiver.
//   rx_state_e      receiver FSM state encoding
//   DATA_BITS       data bits per frame
//   cycles_per_bit  clock cycles per bit for a clock frequency and baud rate
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } rx_state_e;

  function automatic int unsigned cycles_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-FF synchronizer for the serial input, plus falling-edge detect.
//   clk         system clock
//   rst         synchronous reset, active-high (flops reset to line idle = 1)
//   rxd         asynchronous serial input
//   rxs         synchronized serial input
//   start_edge  high in the cycle where rxs is 0 and was 1 in the previous cycle
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rxd,
  output logic rxs,
  output logic start_edge
);

  logic sync1;

  // start_edge is computed from the stage feeding rxs so it lines up with rxs
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1      <= 1'b1;
      rxs        <= 1'b1;
      start_edge <= 1'b0;
    end else begin
      sync1      <= rxd;
      rxs        <= sync1;
      start_edge <= rxs & ~sync1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver, 8 data bits LSB first, 1 start bit, 1 stop bit.
// Optional parity bit enabled by defining the macro UART_RX_PARITY_EN.
//   clk         system clock
//   rst         synchronous reset, active-high
//   rxd         asynchronous serial input, idles high
//   rx_data     received byte, stable while rx_valid=1
//   rx_valid    byte available, held until accepted
//   rx_ready    downstream accept
//   frame_err   one-cycle pulse: stop bit sampled 0
//   overrun     one-cycle pulse: byte completed while rx_valid still held
//   parity_err  one-cycle pulse: parity mismatch (constant 0 without parity)
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam int unsigned CYCLES_PER_BIT = cycles_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int unsigned HALF_BIT       = CYCLES_PER_BIT / 2;
  localparam int unsigned TW             = $clog2(CYCLES_PER_BIT);
  localparam int unsigned IW             = $clog2(DATA_BITS);
  localparam logic        PARITY_SENSE   = 1'(PARITY_ODD);

`ifdef UART_RX_PARITY_EN
  localparam logic PARITY_EN = 1'b1;
`else
  localparam logic PARITY_EN = 1'b0;
`endif

  logic rxs;
  logic start_edge;

  uart_rx_sync u_sync (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .rxs        (rxs),
    .start_edge (start_edge)
  );

  rx_state_e           state, state_d;
  logic [TW-1:0]       bit_timer, bit_timer_d;
  logic [IW-1:0]       bit_idx, bit_idx_d;
  logic [DATA_BITS-1:0] shreg, shreg_d;
  logic                par_bad, par_bad_d;
  logic [7:0]          rx_data_d;
  logic                rx_valid_d, frame_err_d, overrun_d, parity_err_d;

  logic half_done;
  logic bit_done;
  assign half_done = (bit_timer == TW'(HALF_BIT - 1));
  assign bit_done  = (bit_timer == TW'(CYCLES_PER_BIT - 1));

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      bit_timer  <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      par_bad    <= 1'b0;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      state      <= state_d;
      bit_timer  <= bit_timer_d;
      bit_idx    <= bit_idx_d;
      shreg      <= shreg_d;
      par_bad    <= par_bad_d;
      rx_data    <= rx_data_d;
      rx_valid   <= rx_valid_d;
      frame_err  <= frame_err_d;
      overrun    <= overrun_d;
      parity_err <= parity_err_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state;
    bit_timer_d  = bit_timer;
    bit_idx_d    = bit_idx;
    shreg_d      = shreg;
    par_bad_d    = par_bad;
    rx_data_d    = rx_data;
    rx_valid_d   = rx_valid & ~rx_ready;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;
    parity_err_d = 1'b0;

    unique case (state)
      S_IDLE: begin
        bit_timer_d = '0;
        if (start_edge) begin
          state_d = S_START;
        end
      end

      S_START: begin
        if (half_done) begin
          bit_timer_d = '0;
          if (!rxs) begin
            state_d   = S_DATA;
            bit_idx_d = '0;
            par_bad_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          bit_timer_d = bit_timer + TW'(1);
        end
      end

      S_DATA: begin
        if (bit_done) begin
          bit_timer_d = '0;
          shreg_d     = {rxs, shreg[DATA_BITS-1:1]};
          if (bit_idx == IW'(DATA_BITS - 1)) begin
            state_d = PARITY_EN ? S_PARITY : S_STOP;
          end else begin
            bit_idx_d = bit_idx + IW'(1);
          end
        end else begin
          bit_timer_d = bit_timer + TW'(1);
        end
      end

      S_PARITY: begin
        if (bit_done) begin
          bit_timer_d = '0;
          par_bad_d   = rxs ^ (^shreg) ^ PARITY_SENSE;
          state_d     = S_STOP;
        end else begin
          bit_timer_d = bit_timer + TW'(1);
        end
      end

      S_STOP: begin
        if (bit_done) begin
          bit_timer_d = '0;
          state_d     = S_IDLE;
          if (!rxs) begin
            frame_err_d = 1'b1;
          end else if (PARITY_EN && par_bad) begin
            parity_err_d = 1'b1;
          end else if (rx_valid && !rx_ready) begin
            // Held byte not taken yet: keep it, drop the new one
            overrun_d = 1'b1;
          end else begin
            rx_data_d  = shreg;
            rx_valid_d = 1'b1;
          end
        end else begin
          bit_timer_d = bit_timer + TW'(1);
        end
      end

      default: begin
        state_d     = S_IDLE;
        bit_timer_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int unsigned CPB = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  int checks = 0;
  int errors = 0;

  int vcyc = 0, fe_cyc = 0, ov_cyc = 0, pe_cyc = 0;
  logic [7:0] got[$];

  int v0, fe0, ov0, pe0, n0;

  uart_rx #(
    .CLK_FREQ   (1_000_000),
    .BAUD_RATE  (100_000),
    .PARITY_ODD (0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  // Observe outputs mid-cycle; inputs change 2 time units after posedge
  always @(negedge clk) begin
    if (rx_valid) vcyc++;
    if (rx_valid && rx_ready) got.push_back(rx_data);
    if (frame_err) fe_cyc++;
    if (overrun) ov_cyc++;
    if (parity_err) pe_cyc++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] got_at(input int n);
    if (n < got.size()) return got[n];
    return 8'hxx;
  endfunction

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drive_bit(input logic v);
    rxd = v;
    cycles(CPB);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic bad_par);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ bad_par);
`endif
    drive_bit(stop);
    rxd = 1'b1;
  endtask

  task automatic snap();
    v0  = vcyc;
    fe0 = fe_cyc;
    ov0 = ov_cyc;
    pe0 = pe_cyc;
    n0  = got.size();
  endtask

  initial begin
    rst      = 1'b1;
    rxd      = 1'b1;
    rx_ready = 1'b1;
    cycles(5);

    // Reset state
    check("rst_data", 32'(rx_data), 32'h00);
    check("rst_valid", 32'(rx_valid), 32'h0);
    check("rst_ferr", 32'(frame_err), 32'h0);
    check("rst_ovr", 32'(overrun), 32'h0);
    check("rst_perr", 32'(parity_err), 32'h0);
    rst = 1'b0;
    cycles(5);

    // 1: single byte
    snap();
    send_frame(8'h12, 1'b1, 1'b0);
    cycles(5);
    check("t1_count", 32'(got.size() - n0), 32'd1);
    check("t1_data", 32'(got_at(n0)), 32'h12);
    check("t1_vcyc", 32'(vcyc - v0), 32'd1);
    check("t1_ferr", 32'(fe_cyc - fe0), 32'd0);
    check("t1_ovr", 32'(ov_cyc - ov0), 32'd0);
    check("t1_perr", 32'(pe_cyc - pe0), 32'd0);

    // 2: back-to-back frames
    snap();
    send_frame(8'hA5, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0);
    cycles(5);
    check("t2_count", 32'(got.size() - n0), 32'd2);
    check("t2_first", 32'(got_at(n0)), 32'hA5);
    check("t2_second", 32'(got_at(n0 + 1)), 32'h3C);
    check("t2_errs", 32'((fe_cyc - fe0) + (ov_cyc - ov0)), 32'd0);

    // 3: 3-cycle glitch is rejected, then a real byte still decodes
    snap();
    rxd = 1'b0;
    cycles(3);
    rxd = 1'b1;
    cycles(20);
    check("t3_novalid", 32'(vcyc - v0), 32'd0);
    check("t3_noerr", 32'(fe_cyc - fe0), 32'd0);
    send_frame(8'h81, 1'b1, 1'b0);
    cycles(5);
    check("t3_after", 32'(got_at(n0)), 32'h81);

    // 4: bad stop bit
    snap();
    send_frame(8'h55, 1'b0, 1'b0);
    cycles(10);
    check("t4_ferr", 32'(fe_cyc - fe0), 32'd1);
    check("t4_novalid", 32'(vcyc - v0), 32'd0);
    check("t4_count", 32'(got.size() - n0), 32'd0);

    // 5: overrun with downstream stalled
    snap();
    rx_ready = 1'b0;
    send_frame(8'h01, 1'b1, 1'b0);
    send_frame(8'h02, 1'b1, 1'b0);
    cycles(5);
    check("t5_ovr", 32'(ov_cyc - ov0), 32'd1);
    check("t5_valid", 32'(rx_valid), 32'h1);
    check("t5_data", 32'(rx_data), 32'h01);
    rx_ready = 1'b1;
    cycles(3);
    check("t5_accept", 32'(got_at(n0)), 32'h01);
    check("t5_count", 32'(got.size() - n0), 32'd1);
    check("t5_drop", 32'(rx_valid), 32'h0);

    // 6: reset during bit 4 of 8'hFF, then 8'h0F
    snap();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    cycles(4);
    rst = 1'b1;
    cycles(2);
    check("t6_rst_valid", 32'(rx_valid), 32'h0);
    rst = 1'b0;
    cycles(4 + 4 * CPB);
    send_frame(8'h0F, 1'b1, 1'b0);
    cycles(5);
    check("t6_count", 32'(got.size() - n0), 32'd1);
    check("t6_data", 32'(got_at(n0)), 32'h0F);
    check("t6_ferr", 32'(fe_cyc - fe0), 32'd0);
`ifdef UART_RX_PARITY_EN
    snap();
    send_frame(8'h0F, 1'b1, 1'b1);
    cycles(5);
    check("t6_perr", 32'(pe_cyc - pe0), 32'd1);
    check("t6_perr_drop", 32'(got.size() - n0), 32'd0);
`else
    check("t6_perr_tied", 32'(pe_cyc), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
